// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   MEM/WB pipeline register and writeback logic for the RV32I 5-stage pipe.
//   Captures the MEM-stage results, aligns and extends load data, selects the
//   register-file write value and counts retired instructions.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall, flush      hold the WB register / load a bubble (flush wins)
//   mem_*             MEM-stage slot: valid, reg_write, rd, result_src,
//                     funct3, alu_result, read_data, pc_plus4
//   rf_we/rf_a3/rf_wd3  register-file write port (WE3/A3/WD3)
//   fwd_valid/fwd_rd/fwd_data  same-cycle bypass towards decode
//   misalign_err      current WB load is misaligned (its write is suppressed)
//   instret           retired-instruction counter, wraps to 0
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_result_src,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_read_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  output logic             rf_we,
  output logic [4:0]       rf_a3,
  output logic [XLEN-1:0]  rf_wd3,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // WB pipeline register
  logic             wb_valid;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [1:0]       wb_result_src;
  logic [2:0]       wb_funct3;
  logic [XLEN-1:0]  wb_alu_result;
  logic [XLEN-1:0]  wb_read_data;
  logic [XLEN-1:0]  wb_pc_plus4;
  logic [CNT_W-1:0] instret_q;

  // An instruction retires on the edge where it leaves WB; a stalled one
  // stays put, so it is counted exactly once when the stall releases.
  logic retire;
  assign retire = wb_valid & ~stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_result_src <= '0;
      wb_funct3     <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus4   <= '0;
      instret_q     <= '0;
    end else begin
      if (retire) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush) begin
        // Only the valid bit matters for a bubble; payload is left as-is.
        wb_valid <= 1'b0;
      end else if (!stall) begin
        wb_valid      <= mem_valid;
        wb_reg_write  <= mem_reg_write;
        wb_rd         <= mem_rd;
        wb_result_src <= mem_result_src;
        wb_funct3     <= mem_funct3;
        wb_alu_result <= mem_alu_result;
        wb_read_data  <= mem_read_data;
        wb_pc_plus4   <= mem_pc_plus4;
      end
    end
  end

  // Load alignment: memory returns the whole aligned word, the low address
  // bits pick the byte / halfword lane.
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  assign off      = wb_alu_result[1:0];
  assign byte_sel = wb_read_data[{off, 3'b000} +: 8];
  assign half_sel = wb_read_data[{off[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    load_data = wb_read_data;
    case (wb_funct3)
      F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = wb_read_data;
    endcase
  end

  logic is_load;
  logic half_mis;
  logic word_mis;

  assign is_load  = (wb_result_src == SRC_LOAD);
  assign half_mis = ((wb_funct3 == F3_LH) || (wb_funct3 == F3_LHU)) && off[0];
  assign word_mis = (wb_funct3 == F3_LW) && (off != 2'b00);

  assign misalign_err = wb_valid & is_load & (half_mis | word_mis);

  // Result select; the reserved encoding 11 falls back to the ALU result.
  always_comb begin
    rf_wd3 = wb_alu_result;
    case (wb_result_src)
      SRC_LOAD: rf_wd3 = load_data;
      SRC_PC4:  rf_wd3 = wb_pc_plus4;
      default:  rf_wd3 = wb_alu_result;
    endcase
  end

  // x0 is hard-wired to zero, so a write to it is never issued.
  assign rf_we = wb_valid & wb_reg_write & (wb_rd != 5'd0) & ~misalign_err;
  assign rf_a3 = wb_rd;

  // The register file writes on the edge but reads asynchronously, so decode
  // needs this copy of the pending write during the same cycle.
  assign fwd_valid = rf_we;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = rf_wd3;

  assign instret = instret_q;

endmodule
